// File: rtl/apb_mem_arbiter.sv
// Round-robin 2:1 APB arbiter: imem (req 0) and dmem (req 1) share one memory slave.
// Latency: request sampled in IDLE -> SETUP next cycle -> ACCESS; zero-wait reply two cycles after request.
// Backpressure: slave pready stalls ACCESS; silent slave is cut off with pslverr after TIMEOUT cycles.
module apb_mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-fetch upstream port (requester 0)
  input  logic [31:0] imem_paddr,
  input  logic        imem_psel,
  input  logic        imem_penable,
  input  logic        imem_pwrite,
  input  logic [31:0] imem_pwdata,
  input  logic [3:0]  imem_pstrb,
  output logic [31:0] imem_prdata,
  output logic        imem_pready,
  output logic        imem_pslverr,
  // load/store upstream port (requester 1)
  input  logic [31:0] dmem_paddr,
  input  logic        dmem_psel,
  input  logic        dmem_penable,
  input  logic        dmem_pwrite,
  input  logic [31:0] dmem_pwdata,
  input  logic [3:0]  dmem_pstrb,
  output logic [31:0] dmem_prdata,
  output logic        dmem_pready,
  output logic        dmem_pslverr,
  // downstream port to the shared memory
  output logic [31:0] mem_paddr,
  output logic        mem_psel,
  output logic        mem_penable,
  output logic        mem_pwrite,
  output logic [31:0] mem_pwdata,
  output logic [3:0]  mem_pstrb,
  input  logic [31:0] mem_prdata,
  input  logic        mem_pready,
  input  logic        mem_pslverr,
  // status
  output logic [1:0]  grant_o,
  output logic        busy_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Counter keeps at least one bit so a disabled timeout still elaborates.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [1:0]    state;
  logic          gnt;    // current owner: 0 = imem, 1 = dmem
  logic          last;   // last requester served, loses the next tie
  logic [TW-1:0] tcnt;   // ACCESS cycles spent waiting on the slave

  logic        in_xfer;
  logic        in_access;
  logic        done_ok;
  logic        done_to;
  logic        done;
  logic        other_req;
  logic        owner_sel;
  logic        resp_vld;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // Upstream penable carries no information the arbiter needs; psel alone marks a request.
  logic unused_penable;
  assign unused_penable = imem_penable ^ dmem_penable;

  assign in_xfer   = (state == ST_SETUP) || (state == ST_ACCESS);
  assign in_access = (state == ST_ACCESS);
  assign done_ok   = in_access && mem_pready;
  assign done_to   = in_access && !mem_pready && (TIMEOUT != 0) && (tcnt == TLAST);
  assign done      = done_ok || done_to;
  assign other_req = gnt ? imem_psel : dmem_psel;
  assign owner_sel = gnt ? dmem_psel : imem_psel;

  // A master that dropped psel mid-transfer gets no response; the slave side still finishes.
  assign resp_vld   = done && owner_sel;
  assign resp_rdata = done_ok ? mem_prdata : 32'h0;
  assign resp_err   = done_to || (done_ok && mem_pslverr);

  // Downstream request: replay the owner's fields while a transfer is in flight, zeros when idle.
  always_comb begin
    mem_psel    = in_xfer;
    mem_penable = in_access;
    mem_paddr   = 32'h0;
    mem_pwrite  = 1'b0;
    mem_pwdata  = 32'h0;
    mem_pstrb   = 4'h0;
    if (in_xfer) begin
      if (gnt) begin
        mem_paddr  = dmem_paddr;
        mem_pwrite = dmem_pwrite;
        mem_pwdata = dmem_pwdata;
        mem_pstrb  = dmem_pstrb;
      end else begin
        mem_paddr  = imem_paddr;
        mem_pwrite = imem_pwrite;
        mem_pwdata = imem_pwdata;
        mem_pstrb  = imem_pstrb;
      end
    end
  end

  // Upstream response: only the owner ever sees a non-zero reply, in the completing cycle.
  always_comb begin
    imem_pready  = 1'b0;
    imem_prdata  = 32'h0;
    imem_pslverr = 1'b0;
    dmem_pready  = 1'b0;
    dmem_prdata  = 32'h0;
    dmem_pslverr = 1'b0;
    if (resp_vld) begin
      if (gnt) begin
        dmem_pready  = 1'b1;
        dmem_prdata  = resp_rdata;
        dmem_pslverr = resp_err;
      end else begin
        imem_pready  = 1'b1;
        imem_prdata  = resp_rdata;
        imem_pslverr = resp_err;
      end
    end
  end

  // Arbitration FSM: round-robin grant, SETUP/ACCESS sequencing and timeout counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
      tcnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (imem_psel || dmem_psel) begin
            gnt   <= (imem_psel && dmem_psel) ? ~last : dmem_psel;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          tcnt  <= '0;
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (done) begin
            last <= gnt;
            // Hand straight over to a waiting peer; the finishing master's psel is ignored here.
            if (other_req) begin
              gnt   <= ~gnt;
              state <= ST_SETUP;
            end else begin
              state <= ST_IDLE;
            end
          end else if (tcnt != '1) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign grant_o = in_xfer ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign busy_o  = in_xfer;

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Directed bench for apb_mem_arbiter with a small wait-state/silent memory slave model.
// Latency: checks are taken on the falling edge, inputs change 1 time unit after the rising edge.
// Backpressure: slave wait states and a never-ready mode exercise stalls and the timeout path.
module tb_apb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] imem_paddr, imem_pwdata, imem_prdata;
  logic        imem_psel, imem_penable, imem_pwrite, imem_pready, imem_pslverr;
  logic [3:0]  imem_pstrb;
  logic [31:0] dmem_paddr, dmem_pwdata, dmem_prdata;
  logic        dmem_psel, dmem_penable, dmem_pwrite, dmem_pready, dmem_pslverr;
  logic [3:0]  dmem_pstrb;
  logic [31:0] mem_paddr, mem_pwdata, mem_prdata;
  logic        mem_psel, mem_penable, mem_pwrite, mem_pready, mem_pslverr;
  logic [3:0]  mem_pstrb;
  logic [1:0]  grant_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  apb_mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_paddr(imem_paddr), .imem_psel(imem_psel), .imem_penable(imem_penable),
    .imem_pwrite(imem_pwrite), .imem_pwdata(imem_pwdata), .imem_pstrb(imem_pstrb),
    .imem_prdata(imem_prdata), .imem_pready(imem_pready), .imem_pslverr(imem_pslverr),
    .dmem_paddr(dmem_paddr), .dmem_psel(dmem_psel), .dmem_penable(dmem_penable),
    .dmem_pwrite(dmem_pwrite), .dmem_pwdata(dmem_pwdata), .dmem_pstrb(dmem_pstrb),
    .dmem_prdata(dmem_prdata), .dmem_pready(dmem_pready), .dmem_pslverr(dmem_pslverr),
    .mem_paddr(mem_paddr), .mem_psel(mem_psel), .mem_penable(mem_penable),
    .mem_pwrite(mem_pwrite), .mem_pwdata(mem_pwdata), .mem_pstrb(mem_pstrb),
    .mem_prdata(mem_prdata), .mem_pready(mem_pready), .mem_pslverr(mem_pslverr),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory slave: 16 words, programmable wait states, optional never-ready mode.
  logic [31:0] smem [0:15];
  int  waits  = 0;
  bit  silent = 1'b0;
  int  wcnt;

  assign mem_pready  = mem_psel && mem_penable && !silent && (wcnt == waits);
  assign mem_prdata  = smem[mem_paddr[5:2]];
  assign mem_pslverr = 1'b0;

  // Slave storage and wait counter; reset loads a recognisable pattern.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= 0;
      for (int i = 0; i < 16; i++) smem[i] <= {16'hC0DE, 16'(i)};
      smem[2] <= 32'h0000_0013;
    end else if (mem_psel && mem_penable) begin
      if (mem_pready) begin
        wcnt <= 0;
        if (mem_pwrite)
          for (int b = 0; b < 4; b++)
            if (mem_pstrb[b]) smem[mem_paddr[5:2]][8*b +: 8] <= mem_pwdata[8*b +: 8];
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_psel = 0; imem_penable = 0; imem_pwrite = 0; imem_paddr = 0; imem_pwdata = 0; imem_pstrb = 0;
    dmem_psel = 0; dmem_penable = 0; dmem_pwrite = 0; dmem_paddr = 0; dmem_pwdata = 0; dmem_pstrb = 0;
  endtask

  int ncomp;
  int owner;

  initial begin
    rst = 1'b1;
    idle_inputs();

    // ---- reset state ----
    cyc(); cyc(); smp();
    expect_eq("rst_psel", 32'(mem_psel), 0);
    expect_eq("rst_grant", 32'(grant_o), 0);
    expect_eq("rst_busy", 32'(busy_o), 0);
    expect_eq("rst_imem_pready", 32'(imem_pready), 0);
    cyc(); rst = 1'b0;

    // ---- single imem read, zero-wait ----
    cyc(); imem_psel = 1; imem_paddr = 32'h8; smp();
    expect_eq("t1_n_busy", 32'(busy_o), 0);
    cyc(); imem_penable = 1; smp();
    expect_eq("t1_setup_psel", 32'(mem_psel), 1);
    expect_eq("t1_setup_penable", 32'(mem_penable), 0);
    expect_eq("t1_setup_grant", 32'(grant_o), 32'h1);
    expect_eq("t1_setup_paddr", mem_paddr, 32'h8);
    expect_eq("t1_setup_pready", 32'(imem_pready), 0);
    cyc(); smp();
    expect_eq("t1_access_penable", 32'(mem_penable), 1);
    expect_eq("t1_access_grant", 32'(grant_o), 32'h1);
    expect_eq("t1_pready", 32'(imem_pready), 1);
    expect_eq("t1_prdata", imem_prdata, 32'h0000_0013);
    expect_eq("t1_dmem_pready", 32'(dmem_pready), 0);
    cyc(); idle_inputs(); smp();
    expect_eq("t1_after_busy", 32'(busy_o), 0);
    expect_eq("t1_after_paddr", mem_paddr, 0);

    // ---- reset during ACCESS ----
    waits = 3;
    cyc(); dmem_psel = 1; dmem_paddr = 32'h18; smp();
    cyc(); dmem_penable = 1; smp();
    cyc(); smp();
    expect_eq("t6_in_access", 32'(mem_penable), 1);
    rst = 1'b1;
    #1;
    expect_eq("t6_rst_psel", 32'(mem_psel), 0);
    expect_eq("t6_rst_penable", 32'(mem_penable), 0);
    expect_eq("t6_rst_grant", 32'(grant_o), 0);
    expect_eq("t6_rst_busy", 32'(busy_o), 0);
    expect_eq("t6_rst_dmem_pready", 32'(dmem_pready), 0);
    idle_inputs();
    cyc(); cyc(); rst = 1'b0; waits = 0;

    // ---- simultaneous requests after reset: imem wins the tie ----
    cyc();
    imem_psel = 1; imem_paddr = 32'h0;
    dmem_psel = 1; dmem_paddr = 32'h18; dmem_pwrite = 1; dmem_pwdata = 32'hAAAA_AAAA; dmem_pstrb = 4'hF;
    smp();
    cyc(); imem_penable = 1; dmem_penable = 1; smp();
    expect_eq("t2_first_grant", 32'(grant_o), 32'h1);
    expect_eq("t2_first_paddr", mem_paddr, 32'h0);
    cyc(); smp();
    expect_eq("t2_imem_pready", 32'(imem_pready), 1);
    expect_eq("t2_imem_prdata", imem_prdata, 32'hC0DE_0000);
    expect_eq("t2_dmem_wait", 32'(dmem_pready), 0);
    cyc(); imem_psel = 0; imem_penable = 0; smp();
    expect_eq("t2_dmem_setup_grant", 32'(grant_o), 32'h2);
    expect_eq("t2_dmem_setup_penable", 32'(mem_penable), 0);
    expect_eq("t2_dmem_setup_pwrite", 32'(mem_pwrite), 1);
    expect_eq("t2_dmem_setup_paddr", mem_paddr, 32'h18);
    cyc(); smp();
    expect_eq("t2_dmem_pready", 32'(dmem_pready), 1);
    expect_eq("t2_dmem_pslverr", 32'(dmem_pslverr), 0);
    cyc(); idle_inputs(); smp();
    expect_eq("t2_word6", smem[6], 32'hAAAA_AAAA);
    expect_eq("t2_idle", 32'(busy_o), 0);

    // ---- continuous contention: 8 transfers alternating ----
    cyc();
    imem_psel = 1; imem_paddr = 32'h8; imem_penable = 1;
    dmem_psel = 1; dmem_paddr = 32'h4; dmem_penable = 1;
    smp();
    ncomp = 0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (k == 14) begin imem_psel = 0; imem_penable = 0; end
      smp();
      owner = ((k / 2) % 2 == 0) ? 0 : 1;
      expect_eq($sformatf("t3_grant_%0d", k), 32'(grant_o), (owner == 0) ? 32'h1 : 32'h2);
      expect_eq($sformatf("t3_imem_pready_%0d", k), 32'(imem_pready),
                32'((k % 2 == 1) && (owner == 0)));
      expect_eq($sformatf("t3_dmem_pready_%0d", k), 32'(dmem_pready),
                32'((k % 2 == 1) && (owner == 1)));
      if (imem_pready || dmem_pready) ncomp++;
    end
    expect_eq("t3_completions", 32'(ncomp), 32'd8);
    cyc(); idle_inputs(); smp();
    expect_eq("t3_idle", 32'(busy_o), 0);

    // ---- dmem byte write with 3 slave wait states ----
    waits = 3;
    cyc(); dmem_psel = 1; dmem_pwrite = 1; dmem_paddr = 32'h20; dmem_pwdata = 32'h0000_00A5; dmem_pstrb = 4'h1;
    smp();
    for (int j = 1; j <= 5; j++) begin
      cyc();
      if (j == 1) dmem_penable = 1;
      smp();
      if (j >= 2) begin
        expect_eq($sformatf("t4_paddr_%0d", j), mem_paddr, 32'h20);
        expect_eq($sformatf("t4_pwdata_%0d", j), mem_pwdata, 32'h0000_00A5);
        expect_eq($sformatf("t4_pstrb_%0d", j), 32'(mem_pstrb), 32'h1);
        expect_eq($sformatf("t4_penable_%0d", j), 32'(mem_penable), 1);
      end
      expect_eq($sformatf("t4_dmem_pready_%0d", j), 32'(dmem_pready), 32'(j == 5));
      expect_eq($sformatf("t4_imem_pready_%0d", j), 32'(imem_pready), 0);
    end
    cyc(); idle_inputs(); waits = 0; smp();
    expect_eq("t4_word8", smem[8], 32'hC0DE_00A5);

    // ---- timeout with a silent slave, dmem queued behind ----
    silent = 1'b1;
    cyc(); imem_psel = 1; imem_paddr = 32'h8; smp();
    for (int j = 1; j <= 5; j++) begin
      cyc();
      if (j == 1) imem_penable = 1;
      if (j == 3) begin dmem_psel = 1; dmem_paddr = 32'h10; end
      smp();
      expect_eq($sformatf("t5_imem_pready_%0d", j), 32'(imem_pready), 32'(j == 5));
      if (j == 5) begin
        expect_eq("t5_pslverr", 32'(imem_pslverr), 1);
        expect_eq("t5_prdata", imem_prdata, 32'h0);
      end
    end
    cyc(); imem_psel = 0; imem_penable = 0; dmem_penable = 1; silent = 1'b0; smp();
    expect_eq("t5_next_grant", 32'(grant_o), 32'h2);
    expect_eq("t5_next_setup", 32'(mem_penable), 0);
    cyc(); smp();
    expect_eq("t5_dmem_pready", 32'(dmem_pready), 1);
    expect_eq("t5_dmem_prdata", dmem_prdata, 32'hC0DE_0004);
    expect_eq("t5_dmem_pslverr", 32'(dmem_pslverr), 0);
    cyc(); idle_inputs(); smp();
    expect_eq("t5_idle", 32'(busy_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_mem_arbiter.md
# apb_mem_arbiter

Two-to-one APB arbiter that lets the core's instruction-fetch port and its load/store port share one unified memory slave. It sits between `core` (`imem_apb` and `dmem_apb` masters) and a single `apb_slave` memory. It grants the downstream bus round-robin and replays the granted master's transfer downstream. It routes the response back, and ends any transfer the slave never finishes with an error response.

## Interface
- `TIMEOUT`, 16: max downstream ACCESS cycles with `pready`=0 before forced error completion; 0 disables the timeout.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_apb`  apb_if.slave  iface  upstream port for instruction fetch (requester 0).
- `dmem_apb`  apb_if.slave  iface  upstream port for load/store (requester 1).
- `mem_apb`  apb_if.master  iface  downstream port to the shared memory.
- `grant_o`  out  2  one-hot owner of the downstream bus: bit0 = imem, bit1 = dmem; 0 when idle.
- `busy_o`  out  1  high in SETUP or ACCESS.
- APB signals used on every port: `paddr`[31:0], `psel`, `penable`, `pwrite`, `pwdata`[31:0], `pstrb`[3:0], `prdata`[31:0], `pready`, `pslverr`.

## Operation
- State machine: IDLE, SETUP, ACCESS. It also holds a grant register `gnt` (0/1), a `last` register (last requester served) and a timeout counter `tcnt`, which is `$clog2(TIMEOUT+1)` bits wide and saturating.
- IDLE: a requester is pending when its upstream `psel`=1.
  - One pending: grant it.
  - Both pending: grant `!last`.
  - After granting, go to SETUP.
  - No request: stay in IDLE.
- SETUP: drive `mem_apb.psel`=1 and `penable`=0. Forward `paddr/pwrite/pwdata/pstrb` from the granted upstream port. Go to ACCESS. Clear `tcnt`.
- ACCESS: drive `psel`=1 and `penable`=1 with the same forwarded fields.
  - `mem_apb.pready`=1: granted upstream gets `pready`=1, `prdata`=`mem_apb.prdata` and `pslverr`=`mem_apb.pslverr` combinationally in the same cycle. Set `last`=`gnt`. If the other requester's `psel`=1, set `gnt`=other and go directly to SETUP. Otherwise go to IDLE. The completing master's own `psel` is not treated as a new request in this cycle.
  - `mem_apb.pready`=0 and `TIMEOUT`≠0 and `tcnt`==`TIMEOUT`-1: force completion. Upstream gets `pready`=1, `pslverr`=1, `prdata`=0. Next-state rules are the same as a normal completion. The downstream transfer is abandoned.
  - Otherwise: increment `tcnt` and stay in ACCESS.
- Non-granted upstream port: `pready`=0, `prdata`=0, `pslverr`=0 at all times.
- While IDLE, downstream `paddr/pwdata/pstrb/pwrite` = 0.
- If the granted master drops `psel` mid-transfer (protocol violation), the downstream transfer still completes. The response is discarded.
- `grant_o` = one-hot(`gnt`) in SETUP/ACCESS, else 0.

## Timing
- Reset values (async, immediate):
  - State IDLE, `gnt`=0, `last`=1 (imem wins the first tie), `tcnt`=0.
  - All `mem_apb` outputs 0; all upstream `pready/prdata/pslverr` 0; `grant_o`=0, `busy_o`=0.
- Reset mid-transfer: downstream `psel/penable` drop in the same instant. No upstream response is issued. The master restarts after reset.
- Latency:
  - Request sampled in IDLE at cycle N; downstream SETUP at N+1; ACCESS at N+2.
  - With a zero-wait slave, upstream `pready` rises at N+2. This adds one wait state over a native APB access.
  - Each slave wait state adds one cycle.
- Back-to-back, both requesting continuously: ACCESS→SETUP→ACCESS, so one transfer every 2 cycles, alternating imem/dmem.
- Starvation bound: a pending requester is granted no later than after one transfer of the other.
- Timeout: with a silent slave, upstream error `pready` occurs in the `TIMEOUT`-th ACCESS cycle, i.e. cycle N+1+`TIMEOUT`.

## Test plan
- Single imem read: imem `psel` at N with `paddr`=0x8; slave returns 0x00000013, zero wait. Expect downstream SETUP at N+1, ACCESS at N+2, imem `pready`=1 with `prdata`=0x00000013 at N+2, `grant_o`=01 during N+1..N+2.
- Simultaneous requests after reset: imem read 0x0 and dmem write 0xAAAAAAAA to 0x18 with `pstrb`=0xF. Expect imem served first (`grant_o`=01), then dmem SETUP in the cycle after imem completes. Memory word 6 ends as 0xAAAAAAAA; dmem `pready` arrives 2 cycles after imem's.
- Continuous contention for 8 transfers: expect grants alternating 01,10,01,… and exactly one completion every 2 cycles.
- Slave with 3 wait states on a dmem `sb`-style write (`pstrb`=0x1): expect downstream fields stable for all ACCESS cycles, dmem `pready` at N+5, imem `pready` held 0 throughout.
- `TIMEOUT`=4, slave never ready: expect upstream `pready`=1, `pslverr`=1, `prdata`=0 at N+5. Expect the arbiter back in IDLE (or SETUP if the other port is pending) on the next cycle.
- Assert `rst` during ACCESS: expect all outputs 0 immediately. After release, a new imem request completes normally, and `last`=1 (imem wins the next tie).
